// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: one-hot state codes,
// lamp encodings and default phase durations.
package traffic_pkg;

  typedef enum logic [8:0] {
    ST_IDLE = 9'b000000001,
    ST_NS_G = 9'b000000010,
    ST_NS_Y = 9'b000000100,
    ST_AR1  = 9'b000001000,
    ST_EW_G = 9'b000010000,
    ST_EW_Y = 9'b000100000,
    ST_AR2  = 9'b001000000,
    ST_PED  = 9'b010000000,
    ST_EMG  = 9'b100000000
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam int DEF_G_T   = 10;
  localparam int DEF_Y_T   = 5;
  localparam int DEF_AR_T  = 2;
  localparam int DEF_PED_T = 8;

  // A duration must fit the 5-bit counter and be non-zero so the phase can expire.
  function automatic logic dur_ok(input int d);
    return (d >= 1) && (d <= 31);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 5-bit seconds down-counter; expire flags the tick that ends the phase.
module phase_timer #(
  parameter logic [4:0] RST_VAL = 5'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       tick,
  output logic [4:0] count,
  output logic       expire
);

  logic [4:0] count_q;
  logic [4:0] count_d;

  // A load always wins: the owner reloads on the same tick that expires the phase.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q > 5'd1)) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == 5'd1);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer with all-red clearance, latched pedestrian
// walk service and an emergency all-red override.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int G_T   = DEF_G_T,
  parameter int Y_T   = DEF_Y_T,
  parameter int AR_T  = DEF_AR_T,
  parameter int PED_T = DEF_PED_T
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tick_1s,
  input  logic       ped_req,
  input  logic       emg_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [4:0] light_t
);

  if (!dur_ok(G_T) || !dur_ok(Y_T) || !dur_ok(AR_T) || !dur_ok(PED_T)) begin : g_bad_dur
    $error("intersection_scheduler: every duration must lie in 1..31");
  end

  localparam logic [4:0] G_V   = 5'(G_T);
  localparam logic [4:0] Y_V   = 5'(Y_T);
  localparam logic [4:0] AR_V  = 5'(AR_T);
  localparam logic [4:0] PED_V = 5'(PED_T);

  state_t     state_q, state_d;
  logic       ped_pend_q, ped_pend_d;
  logic       ped_to_ew_q, ped_to_ew_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       walk_q, walk_d;
  logic       load_d;
  logic [4:0] load_val_d;
  logic       expire;

  phase_timer #(.RST_VAL(AR_V)) u_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (load_d),
    .load_val (load_val_d),
    .tick     (tick_1s),
    .count    (light_t),
    .expire   (expire)
  );

  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    load_val_d  = '0;
    ped_to_ew_d = ped_to_ew_q;
    ped_pend_d  = ped_pend_q | (ped_req && (state_q != ST_PED));
    unique case (state_q)
      ST_IDLE, ST_AR1, ST_AR2, ST_PED: begin
        if (emg_req) begin
          state_d = ST_EMG;
          load_d  = 1'b1;
          // An interrupted walk is owed again once the override clears.
          if (state_q == ST_PED) ped_pend_d = 1'b1;
        end else if (expire) begin
          load_d = 1'b1;
          if (state_q == ST_IDLE) begin
            state_d    = ST_NS_G;
            load_val_d = G_V;
          end else if (state_q == ST_PED) begin
            state_d    = ped_to_ew_q ? ST_EW_G : ST_NS_G;
            load_val_d = G_V;
          end else if (ped_pend_q || ped_req) begin
            state_d     = ST_PED;
            load_val_d  = PED_V;
            ped_pend_d  = 1'b0;
            ped_to_ew_d = (state_q == ST_AR1);
          end else begin
            state_d    = (state_q == ST_AR1) ? ST_EW_G : ST_NS_G;
            load_val_d = G_V;
          end
        end
      end
      ST_NS_G, ST_EW_G: begin
        if (expire || (tick_1s && emg_req)) begin
          state_d    = (state_q == ST_NS_G) ? ST_NS_Y : ST_EW_Y;
          load_d     = 1'b1;
          load_val_d = Y_V;
        end
      end
      ST_NS_Y, ST_EW_Y: begin
        if (expire) begin
          load_d = 1'b1;
          if (emg_req) begin
            state_d = ST_EMG;
          end else begin
            state_d    = (state_q == ST_NS_Y) ? ST_AR1 : ST_AR2;
            load_val_d = AR_V;
          end
        end
      end
      ST_EMG: begin
        if (tick_1s && !emg_req) begin
          state_d    = ST_AR2;
          load_d     = 1'b1;
          load_val_d = AR_V;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        load_d     = 1'b1;
        load_val_d = AR_V;
      end
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ns_light_d = LT_RED;
    ew_light_d = LT_RED;
    walk_d     = 1'b0;
    unique case (state_d)
      ST_NS_G: ns_light_d = LT_GRN;
      ST_NS_Y: ns_light_d = LT_YEL;
      ST_EW_G: ew_light_d = LT_GRN;
      ST_EW_Y: ew_light_d = LT_YEL;
      ST_PED:  walk_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      ped_pend_q  <= 1'b0;
      ped_to_ew_q <= 1'b0;
      ns_light_q  <= LT_RED;
      ew_light_q  <= LT_RED;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ped_pend_q  <= ped_pend_d;
      ped_to_ew_q <= ped_to_ew_d;
      ns_light_q  <= ns_light_d;
      ew_light_q  <= ew_light_d;
      walk_q      <= walk_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;

  a_one_road_open: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    !((ns_light != LT_RED) && (ew_light != LT_RED)));
  a_walk_in_ped: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    walk |-> (state_q == ST_PED));
  a_count_live: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (state_q != ST_EMG) |-> (light_t != 5'd0));

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: walks the default cycle, pedestrian,
// emergency, tick-stall and mid-phase reset scenarios against hand-computed lamp/count vectors.
module tb_intersection_scheduler;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic       ped_req = 1'b0;
  logic       emg_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [4:0] light_t;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  intersection_scheduler dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick_1s   (tick_1s),
    .ped_req   (ped_req),
    .emg_req   (emg_req),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .light_t   (light_t)
  );

  always #5 sys_clk = ~sys_clk;

  // Vector layout: {ns_light, ew_light, walk, light_t}.
  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got ns=%b ew=%b walk=%b t=%0d, want ns=%b ew=%b walk=%b t=%0d",
               tag, got[11:9], got[8:6], got[5], got[4:0], exp[11:9], exp[8:6], exp[5], exp[4:0]);
    end else begin
      $display("ok   %s: ns=%b ew=%b walk=%b t=%0d", tag, got[11:9], got[8:6], got[5], got[4:0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                            input logic wk, input logic [4:0] t);
    check_val(tag, {ns_light, ew_light, walk, light_t}, {ns, ew, wk, t});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk) tick_1s = 1'b1;
      @(negedge sys_clk) tick_1s = 1'b0;
    end
  endtask

  task automatic pulse_ped();
    @(negedge sys_clk) ped_req = 1'b1;
    @(negedge sys_clk) ped_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    expect_out("reset", R, R, 1'b0, 5'd2);
    sys_rst_n = 1'b1;

    // 1: default free-run cycle
    ticks(1);  expect_out("idle_t1", R, R, 1'b0, 5'd1);
    ticks(1);  expect_out("ns_g_entry", G, R, 1'b0, 5'd10);
    ticks(1);  expect_out("ns_g_dec", G, R, 1'b0, 5'd9);
    ticks(9);  expect_out("ns_y_entry", Y, R, 1'b0, 5'd5);
    ticks(5);  expect_out("ar1_entry", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("ew_g_entry", R, G, 1'b0, 5'd10);
    ticks(10); expect_out("ew_y_entry", R, Y, 1'b0, 5'd5);
    ticks(5);  expect_out("ar2_entry", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("cycle_34", G, R, 1'b0, 5'd10);

    // 2: pedestrian request during NS green
    ticks(3);  expect_out("ns_g_t7", G, R, 1'b0, 5'd7);
    pulse_ped();
    expect_out("ped_latched_hold", G, R, 1'b0, 5'd7);
    ticks(7);  expect_out("p_ns_y", Y, R, 1'b0, 5'd5);
    ticks(5);  expect_out("p_ar1", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("ped_entry", R, R, 1'b1, 5'd8);
    ticks(7);  expect_out("ped_last", R, R, 1'b1, 5'd1);
    ticks(1);  expect_out("ped_to_ew_g", R, G, 1'b0, 5'd10);
    ticks(15); expect_out("p_ar2", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("no_second_ped", G, R, 1'b0, 5'd10);

    // 3: emergency in EW green
    ticks(17); expect_out("e_ew_g", R, G, 1'b0, 5'd10);
    ticks(4);  expect_out("e_ew_g_t6", R, G, 1'b0, 5'd6);
    @(negedge sys_clk) emg_req = 1'b1;
    @(negedge sys_clk);
    expect_out("emg_waits_tick", R, G, 1'b0, 5'd6);
    ticks(1);  expect_out("emg_ew_y", R, Y, 1'b0, 5'd5);
    ticks(4);  expect_out("emg_y_completes", R, Y, 1'b0, 5'd1);
    ticks(1);  expect_out("emg_entry", R, R, 1'b0, 5'd0);
    ticks(1);  expect_out("emg_hold", R, R, 1'b0, 5'd0);
    @(negedge sys_clk) emg_req = 1'b0;
    @(negedge sys_clk);
    expect_out("emg_release_wait", R, R, 1'b0, 5'd0);
    ticks(1);  expect_out("emg_to_ar2", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("emg_resume_ns_g", G, R, 1'b0, 5'd10);

    // 4: emergency during walk keeps the request
    pulse_ped();
    ticks(17); expect_out("w_ped", R, R, 1'b1, 5'd8);
    ticks(3);  expect_out("w_ped_t5", R, R, 1'b1, 5'd5);
    @(negedge sys_clk) emg_req = 1'b1;
    @(negedge sys_clk);
    expect_out("walk_drops", R, R, 1'b0, 5'd0);
    @(negedge sys_clk) emg_req = 1'b0;
    ticks(1);  expect_out("w_ar2", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("ped_kept", R, R, 1'b1, 5'd8);
    ticks(8);  expect_out("ped_to_ns_g", G, R, 1'b0, 5'd10);

    // 5: tick stall, then coincident ped_req and AR expiry
    ticks(2);  expect_out("s_ns_g_t8", G, R, 1'b0, 5'd8);
    repeat (100) @(negedge sys_clk);
    expect_out("stall_hold", G, R, 1'b0, 5'd8);
    ticks(13); expect_out("s_ar1", R, R, 1'b0, 5'd2);
    ticks(1);  expect_out("s_ar1_t1", R, R, 1'b0, 5'd1);
    @(negedge sys_clk) begin tick_1s = 1'b1; ped_req = 1'b1; end
    @(negedge sys_clk) begin tick_1s = 1'b0; ped_req = 1'b0; end
    expect_out("coincident_ped", R, R, 1'b1, 5'd8);
    ticks(8);  expect_out("s_ew_g", R, G, 1'b0, 5'd10);

    // 6: reset mid EW yellow with a pending request
    ticks(10); expect_out("r_ew_y", R, Y, 1'b0, 5'd5);
    ticks(2);  expect_out("r_ew_y_t3", R, Y, 1'b0, 5'd3);
    pulse_ped();
    @(negedge sys_clk) begin sys_rst_n = 1'b0; tick_1s = 1'b1; end
    @(negedge sys_clk) begin sys_rst_n = 1'b1; tick_1s = 1'b0; end
    expect_out("mid_reset", R, R, 1'b0, 5'd2);
    ticks(2);  expect_out("r_ns_g", G, R, 1'b0, 5'd10);
    ticks(17); expect_out("ped_cleared", R, G, 1'b0, 5'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
